// File: rtl/vga_mem_arbiter_rr.sv
// N-channel Wishbone arbiter for the VGA frame-buffer port: optional strict priority for
// channel 0, round-robin for the rest, registered master side and an optional bus timeout.
module vga_mem_arbiter_rr #(
    parameter int NCH        = 3,
    parameter int AW         = 17,
    parameter int DW         = 16,
    parameter int HIPRI      = 1,
    parameter int RDSEL_FULL = 1,
    parameter int TMO        = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NCH*AW-1:0]       s_adr_i,
    input  logic [NCH*(DW/8)-1:0]   s_sel_i,
    input  logic [NCH-1:0]          s_we_i,
    input  logic [NCH*DW-1:0]       s_dat_i,
    input  logic [NCH-1:0]          s_stb_i,
    output logic [DW-1:0]           s_dat_o,
    output logic [NCH-1:0]          s_ack_o,
    output logic [NCH-1:0]          s_err_o,
    output logic [AW-1:0]           wbm_adr_o,
    output logic [(DW/8)-1:0]       wbm_sel_o,
    output logic                    wbm_we_o,
    output logic [DW-1:0]           wbm_dat_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_cyc_o,
    input  logic [DW-1:0]           wbm_dat_i,
    input  logic                    wbm_ack_i,
    output logic [NCH-1:0]          grant_o
);

    localparam int SW = DW / 8;
    localparam int LW = $clog2(NCH);
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] last, owner, win;
    logic [TW-1:0] tmo_cnt;
    logic          err_pend, any_req, tmo_hit, win_we, found;
    int            idx;

    // Round-robin scan starts just after the last served channel.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
        win   = LW'(0);
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(last) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && s_stb_i[idx]) begin
                win   = LW'(idx);
                found = 1'b1;
            end
        end
        if (HIPRI != 0 && s_stb_i[0]) win = LW'(0);
    end

    assign any_req = |s_stb_i;
    assign win_we  = s_we_i[win];
    assign tmo_hit = (TMO > 0) && !wbm_ack_i && (tmo_cnt == TW'(TMO - 1));

    always_ff @(posedge clk_i) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (wbm_ack_i || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbm_adr_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_dat_o <= '0;
            wbm_stb_o <= 1'b0;
            wbm_cyc_o <= 1'b0;
            s_dat_o   <= '0;
            grant_o   <= '0;
            last      <= LW'(NCH - 1);
            owner     <= '0;
            tmo_cnt   <= '0;
            err_pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= win;
                        wbm_adr_o <= s_adr_i[int'(win)*AW +: AW];
                        wbm_sel_o <= (RDSEL_FULL != 0 && !win_we) ? '1 : s_sel_i[int'(win)*SW +: SW];
                        wbm_we_o  <= win_we;
                        wbm_dat_o <= s_dat_i[int'(win)*DW +: DW];
                        wbm_stb_o <= 1'b1;
                        wbm_cyc_o <= 1'b1;
                        grant_o   <= NCH'(1) << win;
                        tmo_cnt   <= '0;
                        err_pend  <= 1'b0;
                    end
                end
                BUSY: begin
                    // An ack in the timeout cycle takes precedence over the error.
                    if (wbm_ack_i) begin
                        if (!wbm_we_o) s_dat_o <= wbm_dat_i;
                        wbm_stb_o <= 1'b0;
                        wbm_cyc_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        last      <= owner;
                        err_pend  <= 1'b0;
                    end else if (tmo_hit) begin
                        wbm_stb_o <= 1'b0;
                        wbm_cyc_o <= 1'b0;
                        last      <= owner;
                        err_pend  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE:    grant_o <= '0;
                default: grant_o <= '0;
            endcase
        end
    end

    // Reply pulse is withheld if the requester has already let go of its strobe.
    always_comb begin
        s_ack_o = '0;
        s_err_o = '0;
        if (state == DONE) begin
            if (err_pend) s_err_o[owner] = s_stb_i[owner];
            else          s_ack_o[owner] = s_stb_i[owner];
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter_rr.sv
// Bench for vga_mem_arbiter_rr: two instances (A: HIPRI=1, TMO=8; B: HIPRI=0, TMO=0), a
// transaction-level model compared every cycle, plus directed literal checks.
module tb_vga_mem_arbiter_rr;

  localparam int NCH = 3;
  localparam int AW  = 17;
  localparam int DW  = 16;
  localparam int SW  = DW / 8;

  logic clk;
  logic rst [2];
  logic [NCH*AW-1:0] s_adr [2];
  logic [NCH*SW-1:0] s_sel [2];
  logic [NCH-1:0]    s_we [2], s_stb [2];
  logic [NCH*DW-1:0] s_dat [2];
  logic [DW-1:0]     s_dat_o [2];
  logic [NCH-1:0]    s_ack_o [2], s_err_o [2], grant [2];
  logic [AW-1:0]     wbm_adr [2];
  logic [SW-1:0]     wbm_sel [2];
  logic              wbm_we [2], wbm_stb [2], wbm_cyc [2], wbm_ack [2];
  logic [DW-1:0]     wbm_dat_o [2], wbm_dat_i [2];

  int ws [2];
  bit hang [2];
  int scnt [2];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  vga_mem_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .HIPRI(1), .RDSEL_FULL(1), .TMO(8)) dut_a (
    .clk_i(clk), .rst_i(rst[0]),
    .s_adr_i(s_adr[0]), .s_sel_i(s_sel[0]), .s_we_i(s_we[0]), .s_dat_i(s_dat[0]), .s_stb_i(s_stb[0]),
    .s_dat_o(s_dat_o[0]), .s_ack_o(s_ack_o[0]), .s_err_o(s_err_o[0]),
    .wbm_adr_o(wbm_adr[0]), .wbm_sel_o(wbm_sel[0]), .wbm_we_o(wbm_we[0]), .wbm_dat_o(wbm_dat_o[0]),
    .wbm_stb_o(wbm_stb[0]), .wbm_cyc_o(wbm_cyc[0]), .wbm_dat_i(wbm_dat_i[0]), .wbm_ack_i(wbm_ack[0]),
    .grant_o(grant[0])
  );

  vga_mem_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .HIPRI(0), .RDSEL_FULL(1), .TMO(0)) dut_b (
    .clk_i(clk), .rst_i(rst[1]),
    .s_adr_i(s_adr[1]), .s_sel_i(s_sel[1]), .s_we_i(s_we[1]), .s_dat_i(s_dat[1]), .s_stb_i(s_stb[1]),
    .s_dat_o(s_dat_o[1]), .s_ack_o(s_ack_o[1]), .s_err_o(s_err_o[1]),
    .wbm_adr_o(wbm_adr[1]), .wbm_sel_o(wbm_sel[1]), .wbm_we_o(wbm_we[1]), .wbm_dat_o(wbm_dat_o[1]),
    .wbm_stb_o(wbm_stb[1]), .wbm_cyc_o(wbm_cyc[1]), .wbm_dat_i(wbm_dat_i[1]), .wbm_ack_i(wbm_ack[1]),
    .grant_o(grant[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Slave: acks after ws[k] wait cycles of strobe, never when hang[k] is set.
  initial begin
    for (int k = 0; k < 2; k++) begin
      wbm_ack[k] = 1'b0;
      scnt[k] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (wbm_stb[k] && !hang[k]) begin
          if (scnt[k] == ws[k]) begin
            wbm_ack[k] = 1'b1;
            scnt[k] = 0;
          end else begin
            wbm_ack[k] = 1'b0;
            scnt[k]++;
          end
        end else begin
          wbm_ack[k] = 1'b0;
          scnt[k] = 0;
        end
      end
    end
  end

  // ---------------- transaction-level model ----------------
  bit             m_busy [2], m_done [2], m_err [2], m_we [2];
  int             m_owner [2], m_last [2], m_cnt [2];
  logic [AW-1:0]  m_adr [2];
  logic [SW-1:0]  m_sel [2];
  logic [DW-1:0]  m_dat [2], m_rd [2];

  function automatic int hip_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int tmo_of(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  function automatic int pick(input int k);
    if (hip_of(k) != 0 && s_stb[k][0]) return 0;
    for (int i = 1; i <= NCH; i++) begin
      int c = (m_last[k] + i) % NCH;
      if (s_stb[k][c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset(input int k);
    m_busy[k] = 0; m_done[k] = 0; m_err[k] = 0; m_we[k] = 0;
    m_owner[k] = 0; m_last[k] = NCH - 1; m_cnt[k] = 0;
    m_adr[k] = '0; m_sel[k] = '0; m_dat[k] = '0; m_rd[k] = '0;
  endtask

  task automatic model_step(input int k);
    int c;
    if (rst[k]) model_reset(k);
    else if (m_done[k]) m_done[k] = 0;
    else if (m_busy[k]) begin
      if (wbm_ack[k]) begin
        if (!m_we[k]) m_rd[k] = wbm_dat_i[k];
        m_we[k] = 0; m_busy[k] = 0; m_done[k] = 1; m_err[k] = 0; m_last[k] = m_owner[k];
      end else if (tmo_of(k) > 0 && m_cnt[k] == tmo_of(k) - 1) begin
        m_busy[k] = 0; m_done[k] = 1; m_err[k] = 1; m_last[k] = m_owner[k];
      end else m_cnt[k]++;
    end else if (s_stb[k] != '0) begin
      c = pick(k);
      m_owner[k] = c;
      m_adr[k] = s_adr[k][c*AW +: AW];
      m_we[k] = s_we[k][c];
      m_sel[k] = m_we[k] ? s_sel[k][c*SW +: SW] : '1;
      m_dat[k] = s_dat[k][c*DW +: DW];
      m_busy[k] = 1; m_cnt[k] = 0;
    end
  endtask

  task automatic cmp_all(input int k);
    logic [NCH-1:0] eg, ea, ee;
    eg = '0; ea = '0; ee = '0;
    if (m_busy[k] || m_done[k]) eg[m_owner[k]] = 1'b1;
    if (m_done[k] && s_stb[k][m_owner[k]]) begin
      if (m_err[k]) ee[m_owner[k]] = 1'b1;
      else          ea[m_owner[k]] = 1'b1;
    end
    check("wbm_stb", k, wbm_stb[k], m_busy[k]);
    check("wbm_cyc", k, wbm_cyc[k], m_busy[k]);
    check("wbm_we", k, wbm_we[k], m_we[k]);
    check("wbm_adr", k, wbm_adr[k], m_adr[k]);
    check("wbm_sel", k, wbm_sel[k], m_sel[k]);
    check("wbm_dat", k, wbm_dat_o[k], m_dat[k]);
    check("grant", k, grant[k], eg);
    check("s_ack", k, s_ack_o[k], ea);
    check("s_err", k, s_err_o[k], ee);
    check("s_dat", k, s_dat_o[k], m_rd[k]);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (chk_en) cmp_all(k);
        model_step(k);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [AW-1:0]  t_adr;
  logic [SW-1:0]  t_sel;
  logic           t_we;
  logic [DW-1:0]  t_dat;
  logic [NCH-1:0] t_ack, t_err, t_grant, prev_g;
  int             t_stb_cyc, t_done_cyc, t_stb_cnt;
  int             gseq [$];
  int             nack, last_ack, gap_bad, bad_g;
  logic [NCH-1:0] exp_g [6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watches one transfer: cycle index 0 is the first negedge after the call.
  task automatic xfer_watch(input int k, input int limit);
    t_stb_cyc = -1; t_done_cyc = -1; t_stb_cnt = 0;
    t_ack = '0; t_err = '0; t_grant = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (wbm_stb[k]) begin
        t_stb_cnt++;
        if (t_stb_cyc < 0) begin
          t_stb_cyc = i; t_adr = wbm_adr[k]; t_sel = wbm_sel[k];
          t_we = wbm_we[k]; t_dat = wbm_dat_o[k]; t_grant = grant[k];
        end
      end
      if ((s_ack_o[k] | s_err_o[k]) != '0) begin
        t_done_cyc = i; t_ack = s_ack_o[k]; t_err = s_err_o[k];
        break;
      end
    end
    check("xfer_completed", k, t_done_cyc >= 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; s_adr[k] = '0; s_sel[k] = '0; s_we[k] = '0; s_dat[k] = '0; s_stb[k] = '0;
      wbm_dat_i[k] = '0; ws[k] = 0; hang[k] = 0;
    end
    tick(2);
    chk_en = 1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_grant", k, grant[k], 3'b000);
      check("rst_stb", k, wbm_stb[k], 1'b0);
      check("rst_sdat", k, s_dat_o[k], 16'h0000);
    end

    // Read on channel 1 of A, one wait state.
    tick(1);
    s_adr[0][AW +: AW] = 17'h00123; s_sel[0][SW +: SW] = 2'b01; s_we[0][1] = 1'b0;
    ws[0] = 1; wbm_dat_i[0] = 16'hBEEF; s_stb[0][1] = 1'b1;
    xfer_watch(0, 20);
    check("rd_stb_latency", 0, t_stb_cyc, 1);
    check("rd_adr", 0, t_adr, 17'h00123);
    check("rd_sel", 0, t_sel, 2'b11);
    check("rd_we", 0, t_we, 1'b0);
    check("rd_grant", 0, t_grant, 3'b010);
    check("rd_ack_latency", 0, t_done_cyc, 3);
    check("rd_ack", 0, t_ack, 3'b010);
    check("rd_data", 0, s_dat_o[0], 16'hBEEF);
    tick(1);
    s_stb[0][1] = 1'b0;

    // Write on channel 2 of A, zero-wait slave.
    tick(2);
    s_adr[0][2*AW +: AW] = 17'h00456; s_sel[0][2*SW +: SW] = 2'b01; s_we[0][2] = 1'b1;
    s_dat[0][2*DW +: DW] = 16'h00A5; ws[0] = 0; wbm_dat_i[0] = 16'h1234; s_stb[0][2] = 1'b1;
    xfer_watch(0, 20);
    check("wr_we", 0, t_we, 1'b1);
    check("wr_sel", 0, t_sel, 2'b01);
    check("wr_dat", 0, t_dat, 16'h00A5);
    check("wr_ack_latency", 0, t_done_cyc, 2);
    check("wr_ack", 0, t_ack, 3'b100);
    check("wr_sdat_kept", 0, s_dat_o[0], 16'hBEEF);
    tick(1);
    s_stb[0][2] = 1'b0;

    // HIPRI on A: channels 0 and 1 both request; 0 wins until it lets go.
    tick(2);
    s_we[0] = '0; s_stb[0] = 3'b011;
    prev_g = '0; bad_g = 0; gseq.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (grant[0] != '0 && prev_g == '0) begin
        gseq.push_back(int'(grant[0]));
        if (grant[0] != 3'b001) bad_g++;
      end
      prev_g = grant[0];
    end
    check("hipri_grants", 0, gseq.size(), 4);
    check("hipri_not_ch0", 0, bad_g, 0);
    tick(1);
    s_stb[0][0] = 1'b0;
    xfer_watch(0, 10);
    check("hipri_ch1_grant", 0, t_grant, 3'b010);
    check("hipri_ch1_latency", 0, t_stb_cyc, 1);
    tick(1);
    s_stb[0] = '0;

    // Timeout on A: slave never acks channel 1.
    tick(2);
    hang[0] = 1; s_stb[0][1] = 1'b1;
    xfer_watch(0, 20);
    check("tmo_busy_cycles", 0, t_stb_cnt, 8);
    check("tmo_err_cycle", 0, t_done_cyc, 9);
    check("tmo_err", 0, t_err, 3'b010);
    check("tmo_no_ack", 0, t_ack, 3'b000);
    tick(1);
    s_stb[0] = '0; hang[0] = 0;

    // Round robin on B: all strobes held, zero-wait slave.
    tick(2);
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    exp_g[3] = 3'b001; exp_g[4] = 3'b010; exp_g[5] = 3'b100;
    s_adr[1] = {17'h00300, 17'h00200, 17'h00100}; s_we[1] = '0; ws[1] = 0;
    wbm_dat_i[1] = 16'hC0DE; s_stb[1] = 3'b111;
    prev_g = '0; gseq.delete(); nack = 0; last_ack = -10; gap_bad = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (grant[1] != '0 && prev_g == '0) gseq.push_back(int'(grant[1]));
      prev_g = grant[1];
      if (s_ack_o[1] != '0) begin
        nack++;
        if (nack > 1 && i - last_ack != 3) gap_bad++;
        last_ack = i;
      end
    end
    check("rr_grant_count", 1, gseq.size(), 6);
    for (int j = 0; j < 6; j++)
      if (j < gseq.size()) check("rr_grant_order", 1, gseq[j], exp_g[j]);
    check("rr_ack_count", 1, nack, 6);
    check("rr_ack_spacing", 1, gap_bad, 0);
    tick(1);
    s_stb[1] = '0;

    // Reset during BUSY on B: serve ch0 first so the pointer is not already at its reset value.
    tick(2);
    s_stb[1][0] = 1'b1;
    xfer_watch(1, 10);
    check("pre_rst_ack", 1, t_ack, 3'b001);
    tick(1);
    s_stb[1] = '0;
    tick(2);
    hang[1] = 1; s_stb[1][2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wbm_stb[1]) break;
    end
    check("busy_grant", 1, grant[1], 3'b100);
    tick(1);
    rst[1] = 1'b1;
    tick(1);
    rst[1] = 1'b0; s_stb[1][0] = 1'b1; hang[1] = 0;
    @(negedge clk);
    check("rst_abort_stb", 1, wbm_stb[1], 1'b0);
    check("rst_abort_grant", 1, grant[1], 3'b000);
    check("rst_abort_ack", 1, s_ack_o[1], 3'b000);
    check("rst_abort_err", 1, s_err_o[1], 3'b000);
    xfer_watch(1, 10);
    check("post_rst_grant", 1, t_grant, 3'b001);
    check("post_rst_ack", 1, t_ack, 3'b001);
    tick(1);
    s_stb[1] = '0;

    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
